// File: rtl/reel_sequencer.sv
// Three-reel slot sequencer: LFSR start positions, divided-rate reel stepping,
// in-order reel stops (player pulse or auto timeout) and a match check.
module reel_sequencer #(
  parameter int          TICK_DIV        = 2500000,
  parameter int          AUTO_STOP_TICKS = 40,
  parameter int          MIN_SPIN_TICKS  = 8,
  parameter int          NUM_SYMBOLS     = 6,
  parameter int          SYM_W           = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             spin_i,
  input  logic             stop_pulse_i,
  input  logic             abort_i,
  output logic [SYM_W-1:0] reel0_o,
  output logic [SYM_W-1:0] reel1_o,
  output logic [SYM_W-1:0] reel2_o,
  output logic [2:0]       spinning_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             win_o
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int AUTO_W = (AUTO_STOP_TICKS < 2) ? 1 : $clog2(AUTO_STOP_TICKS);
  localparam int SPUN_W = (MIN_SPIN_TICKS < 1) ? 1 : $clog2(MIN_SPIN_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_STOP_TICKS - 1);
  localparam logic [SPUN_W-1:0] SPUN_MAX  = SPUN_W'(MIN_SPIN_TICKS);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(NUM_SYMBOLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_EVAL} state_t;

  state_t                   state_reg, state_next;
  logic [15:0]              lfsr_reg;
  logic                     lfsr_fb;
  logic [TICK_W-1:0]        tick_cnt_reg;
  logic [AUTO_W-1:0]        auto_cnt_reg;
  logic [SPUN_W-1:0]        spun_reg;
  logic [1:0]               stop_idx_reg;
  logic [2:0]               spinning_reg;
  logic                     done_reg;
  logic                     win_reg;
  logic [2:0][SYM_W-1:0]    reel_vec;
  logic                     in_spin, abort_hit, spin_go, tick, stop_go;

  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign in_spin   = (state_reg == S_SPIN);
  assign abort_hit = abort_i && (state_reg != S_IDLE);
  assign spin_go   = spin_i && (state_reg == S_IDLE);
  assign tick      = in_spin && (tick_cnt_reg == TICK_LAST);
  // A coincident player stop and timeout collapse into one stop.
  assign stop_go   = in_spin && !abort_i &&
                     ((stop_pulse_i && (spun_reg >= SPUN_MAX)) ||
                      (tick && (auto_cnt_reg == AUTO_LAST)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (spin_i) state_next = S_SPIN;
      S_SPIN: begin
        if (abort_i)                                 state_next = S_IDLE;
        else if (stop_go && (stop_idx_reg == 2'd2))  state_next = S_EVAL;
      end
      S_EVAL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_reg != S_IDLE);
    done_o     = done_reg;
    win_o      = win_reg;
    spinning_o = spinning_reg;
    reel0_o    = reel_vec[0];
    reel1_o    = reel_vec[1];
    reel2_o    = reel_vec[2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_reg     <= LFSR_SEED;
      tick_cnt_reg <= '0;
      auto_cnt_reg <= '0;
      spun_reg     <= '0;
      stop_idx_reg <= '0;
      spinning_reg <= '0;
      done_reg     <= 1'b0;
      win_reg      <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      done_reg <= 1'b0;
      if (abort_hit) begin
        spinning_reg <= '0;
        win_reg      <= 1'b0;
      end else if (spin_go) begin
        spinning_reg <= 3'b111;
        win_reg      <= 1'b0;
        tick_cnt_reg <= '0;
        auto_cnt_reg <= '0;
        spun_reg     <= '0;
        stop_idx_reg <= '0;
      end else if (in_spin) begin
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
        if (tick && (spun_reg != SPUN_MAX)) spun_reg <= spun_reg + 1'b1;
        if (stop_go) begin
          spinning_reg[stop_idx_reg] <= 1'b0;
          stop_idx_reg               <= stop_idx_reg + 2'd1;
          auto_cnt_reg               <= '0;
        end else if (tick) begin
          auto_cnt_reg <= auto_cnt_reg + 1'b1;
        end
      end else if (state_reg == S_EVAL) begin
        win_reg  <= (reel_vec[0] == reel_vec[1]) && (reel_vec[1] == reel_vec[2]);
        done_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_reel
    logic [SYM_W-1:0] seed_raw, seed_val, reel_reg;
    logic             reel_step;

    assign seed_raw  = lfsr_reg[gi*SYM_W +: SYM_W];
    assign seed_val  = (seed_raw > SYM_LAST) ? seed_raw - SYM_LAST - 1'b1 : seed_raw;
    // The reel being stopped freezes on this edge even if a tick lands on it.
    assign reel_step = tick && !abort_i && spinning_reg[gi] &&
                       !(stop_go && (stop_idx_reg == 2'(gi)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        reel_reg <= '0;
      else if (spin_go)   reel_reg <= seed_val;
      else if (reel_step) reel_reg <= (reel_reg == SYM_LAST) ? '0 : reel_reg + 1'b1;
    end

    assign reel_vec[gi] = reel_reg;
  end

endmodule

// File: tb/tb_reel_sequencer.sv
// Bench for reel_sequencer: behavioural play model compared every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_reel_sequencer;
  localparam int          TICK_DIV        = 4;
  localparam int          AUTO_STOP_TICKS = 10;
  localparam int          MIN_SPIN_TICKS  = 2;
  localparam int          NUM_SYMBOLS     = 6;
  localparam int          SYM_W           = 3;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;

  logic             clk_i = 1'b0, rst_ni = 1'b0;
  logic             spin_i = 1'b0, stop_pulse_i = 1'b0, abort_i = 1'b0;
  logic [SYM_W-1:0] reel0_o, reel1_o, reel2_o;
  logic [2:0]       spinning_o;
  logic             busy_o, done_o, win_o;

  reel_sequencer #(
    .TICK_DIV(TICK_DIV), .AUTO_STOP_TICKS(AUTO_STOP_TICKS), .MIN_SPIN_TICKS(MIN_SPIN_TICKS),
    .NUM_SYMBOLS(NUM_SYMBOLS), .SYM_W(SYM_W), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .spin_i(spin_i), .stop_pulse_i(stop_pulse_i),
    .abort_i(abort_i), .reel0_o(reel0_o), .reel1_o(reel1_o), .reel2_o(reel2_o),
    .spinning_o(spinning_o), .busy_o(busy_o), .done_o(done_o), .win_o(win_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Play model: counts edges and ticks since the spin and derives stops from them.
  logic [15:0] m_lfsr;
  int          m_reel[3];
  logic [2:0]  m_spin;
  bit          m_playing, m_eval, m_done, m_win;
  int          m_cyc, m_ticks, m_last_stop, m_nstop;

  task automatic model_reset();
    m_lfsr = LFSR_SEED;
    for (int k = 0; k < 3; k++) m_reel[k] = 0;
    m_spin = 3'b000; m_playing = 0; m_eval = 0; m_done = 0; m_win = 0;
    m_cyc = 0; m_ticks = 0; m_last_stop = 0; m_nstop = 0;
  endtask

  task automatic model_step();
    logic [15:0] cur;
    bit tick, accept;
    if (!rst_ni) return;
    cur = m_lfsr;
    m_lfsr = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    m_done = 0;
    if (m_eval) begin
      m_eval = 0;
      if (abort_i) m_win = 0;
      else begin
        m_win  = (m_reel[0] == m_reel[1]) && (m_reel[1] == m_reel[2]);
        m_done = 1;
      end
    end else if (m_playing) begin
      if (abort_i) begin
        m_playing = 0; m_spin = 3'b000; m_win = 0;
      end else begin
        tick = (m_cyc % TICK_DIV) == TICK_DIV - 1;
        m_cyc++;
        accept = (stop_pulse_i && m_ticks >= MIN_SPIN_TICKS) ||
                 (tick && (m_ticks - m_last_stop) == AUTO_STOP_TICKS - 1);
        for (int k = 0; k < 3; k++)
          if (tick && m_spin[k] && !(accept && k == m_nstop))
            m_reel[k] = (m_reel[k] + 1) % NUM_SYMBOLS;
        if (tick) m_ticks++;
        if (accept) begin
          m_spin[m_nstop] = 1'b0;
          m_nstop++;
          m_last_stop = m_ticks;
          if (m_nstop == 3) begin m_playing = 0; m_eval = 1; end
        end
      end
    end else if (spin_i) begin
      for (int k = 0; k < 3; k++) m_reel[k] = int'(cur[k*SYM_W +: SYM_W]) % NUM_SYMBOLS;
      m_spin = 3'b111; m_win = 0; m_playing = 1;
      m_cyc = 0; m_ticks = 0; m_last_stop = 0; m_nstop = 0;
    end
  endtask

  always @(negedge clk_i) begin
    if (check_en) begin
      chk("reel0", int'(reel0_o), m_reel[0]);
      chk("reel1", int'(reel1_o), m_reel[1]);
      chk("reel2", int'(reel2_o), m_reel[2]);
      chk("spinning", int'(spinning_o), int'(m_spin));
      chk("busy", int'(busy_o), int'(m_playing || m_eval));
      chk("done", int'(done_o), int'(m_done));
      chk("win", int'(win_o), int'(m_win));
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive(input bit s, input bit st, input bit ab);
    spin_i = s; stop_pulse_i = st; abort_i = ab;
    cycle();
    spin_i = 0; stop_pulse_i = 0; abort_i = 0;
  endtask

  // Presses stop on a non-tick edge when the next reel shows its target (-1: never).
  task automatic run_play(input int t0, input int t1, input int t2);
    int tgt[3];
    bit press, got;
    tgt[0] = t0; tgt[1] = t1; tgt[2] = t2;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      press = m_playing && (m_ticks >= MIN_SPIN_TICKS) && ((m_cyc % TICK_DIV) != TICK_DIV - 1) &&
              (m_nstop < 3) && (m_reel[m_nstop] == tgt[m_nstop]);
      drive(0, press, 0);
      if (done_o) got = 1;
    end
    chk("play_done_seen", int'(got), 1);
  endtask

  initial begin
    int s0, s1, s2, dn, dn_cnt;
    bit reached;
    model_reset();
    check_en = 1;
    cycle(); cycle();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_spinning", int'(spinning_o), 0);
    chk("rst_reel0", int'(reel0_o), 0);

    // spin on the very first edge: slices of the seed 0xACE1
    rst_ni = 1;
    drive(1, 0, 0);
    chk("seed_reel0", int'(reel0_o), 1);
    chk("seed_reel1", int'(reel1_o), 4);
    chk("seed_reel2", int'(reel2_o), 3);
    chk("seed_spinning", int'(spinning_o), 7);
    drive(0, 0, 1);
    chk("abort_spinning", int'(spinning_o), 0);
    chk("abort_hold_reel0", int'(reel0_o), 1);

    // spin on the second edge: slices of 0x59C3, reel2 raw 7 reduces to 1
    rst_ni = 0; model_reset(); cycle(); rst_ni = 1;
    drive(0, 0, 0);
    drive(1, 0, 0);
    chk("lfsr2_reel0", int'(reel0_o), 3);
    chk("lfsr2_reel1", int'(reel1_o), 0);
    chk("lfsr2_reel2", int'(reel2_o), 1);
    for (int n = 1; n <= 12; n++) begin
      drive(0, (n == 5) || (n == 12), 0);
      if (n == 5) chk("early_stop_ignored", int'(spinning_o), 7);
    end
    chk("tick_stop_spinning", int'(spinning_o), 6);
    chk("tick_stop_reel0", int'(reel0_o), 5);
    chk("tick_stop_reel1", int'(reel1_o), 3);
    chk("tick_stop_reel2", int'(reel2_o), 4);
    run_play(-1, -1, -1);

    // auto-stop timing with no player input
    drive(1, 0, 0);
    s0 = -1; s1 = -1; s2 = -1; dn = -1; dn_cnt = 0;
    for (int n = 1; n <= 130; n++) begin
      drive(0, 0, 0);
      if (spinning_o == 3'b110 && s0 < 0) s0 = n;
      if (spinning_o == 3'b100 && s1 < 0) s1 = n;
      if (spinning_o == 3'b000 && s2 < 0) s2 = n;
      if (done_o) begin dn_cnt++; if (dn < 0) dn = n; end
    end
    chk("auto_stop0_edge", s0, 40);
    chk("auto_stop1_edge", s1, 80);
    chk("auto_stop2_edge", s2, 120);
    chk("done_edge", dn, 121);
    chk("done_pulses", dn_cnt, 1);
    chk("idle_after_play", int'(busy_o), 0);

    // aligned stops: win held until the next spin
    drive(1, 0, 0);
    run_play(3, 3, 3);
    chk("win_at_done", int'(win_o), 1);
    drive(0, 0, 0); drive(0, 0, 0);
    chk("win_held", int'(win_o), 1);
    drive(1, 0, 0);
    chk("win_cleared_by_spin", int'(win_o), 0);
    run_play(3, 3, 3);
    chk("win_second", int'(win_o), 1);
    drive(1, 0, 0);
    chk("spin_in_done_busy", int'(busy_o), 1);
    chk("spin_in_done_win", int'(win_o), 0);
    run_play(3, 3, 2);
    chk("mismatch_no_win", int'(win_o), 0);

    // abort with only reel2 still spinning
    drive(1, 0, 0);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      drive(0, (m_ticks >= MIN_SPIN_TICKS) && (m_nstop < 2) && (m_cyc % 2 == 0), 0);
      if (spinning_o == 3'b100) reached = 1;
    end
    chk("reached_100", int'(reached), 1);
    drive(0, 0, 1);
    chk("abort_to_idle", int'(busy_o), 0);
    chk("abort_spin_clear", int'(spinning_o), 0);
    dn_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0);
      if (done_o || spinning_o != 3'b000) dn_cnt++;
    end
    chk("idle_stop_no_effect", dn_cnt, 0);

    // asynchronous reset in the middle of a spin
    drive(1, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 0);
    @(posedge clk_i);
    model_step();
    #2 rst_ni = 0;
    #1;
    chk("async_reel0", int'(reel0_o), 0);
    chk("async_reel1", int'(reel1_o), 0);
    chk("async_reel2", int'(reel2_o), 0);
    chk("async_spinning", int'(spinning_o), 0);
    chk("async_busy", int'(busy_o), 0);
    model_reset();
    @(negedge clk_i); #1;
    cycle();
    rst_ni = 1;

    // randomized play
    for (int i = 0; i < 2500; i++) begin
      bit s, st, ab;
      s  = (!busy_o && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 299) == 0);
      drive(s, st, ab);
    end

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
